sad_acc_best: RTL and testbench
===============================

Name: sad_acc_best

Overview:
- Parametrised successor to the fixed 8x8 `sad` block in `core/`.
- Streams one block row per accepted cycle and accumulates |pre-crt| over ROWS rows per candidate.
- Emits one SAD per candidate, and tracks the minimum SAD and its candidate id across a search window.
- Sits between the reference/current row fetch and the motion-vector decision logic of the 4K60 ME core.

Parameters:
- PW, 8: pixel bit width.
- PIX, 8: pixels per row (power of two, >=2).
- ROWS, 8: rows per candidate block (power of two, >=2).
- IDX_W, 10: candidate id width.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset. Asynchronous, active-low.
- in_valid  in  1  row present this cycle.
- search_clr  in  1  one-cycle pulse; starts a new search window.
- cand_id  in  IDX_W  candidate id, sampled on row 0 of each candidate.
- pre_frame  in  PIX*PW  reference row; pixel i at bits [i*PW +: PW].
- crt_frame  in  PIX*PW  current row, same packing.
- sad_data  out  SAD_W  SAD of the last completed candidate; SAD_W = PW + log2(PIX*ROWS), which is 14 at defaults.
- sad_valid  out  1  one-cycle pulse; sad_data/sad_id are valid.
- sad_id  out  IDX_W  id of the candidate in sad_data.
- best_sad  out  SAD_W  minimum SAD in the current window.
- best_id  out  IDX_W  id of best_sad.
- best_valid  out  1  at least one candidate has completed since the last clear.

Behaviour:
- Reset (async assert, sync release): all outputs 0, row counter 0, pipeline valid bits 0, accumulator 0.
- Row counter: advances only on in_valid and wraps ROWS-1 -> 0. Gaps in in_valid are allowed anywhere and do not affect results.
- Pipeline, 3 registered stages:
  - S1: per-pixel |pre-crt|, PW bits each (unsigned compare-and-subtract, no overflow).
  - S2: adder tree to a row sum of PW+log2(PIX) bits.
  - S3: accumulator. Row 0 loads the row sum; other rows add it.
  - Each stage carries a valid bit, first/last-row tags and the cand_id captured at row 0.
- Latency: if the last row of a candidate is presented in cycle N, sad_valid is high in cycle N+3 only, with the full sum in sad_data and the row-0 id in sad_id.
- sad_data and sad_id hold their values until the next sad_valid.
- Throughput: one row per cycle; back-to-back candidates need no bubble.
- Width: the accumulator is SAD_W bits and cannot overflow (max = (2^PW - 1)*PIX*ROWS).
- Best tracker, evaluated in the cycle sad_valid is high, with registered update:
  - If best_valid==0 or sad_data < best_sad (strict): best_sad<=sad_data, best_id<=sad_id, best_valid<=1.
  - Ties keep the earlier candidate.
  - The best_* outputs reflect the update from cycle N+4.
- search_clr has priority over all in-flight work:
  - Row counter <= 0.
  - S1..S3 valid bits <= 0; partial sums and pending sad_valid are discarded.
  - best_valid <= 0; best_sad and best_id hold their stale values but are don't-care.
- in_valid in the same cycle as search_clr: that row is accepted as row 0 of the first candidate of the new window.
- Reset mid-block: identical to search_clr plus all outputs zeroed. No result is emitted for the partial block.

Decomposition:
- Package sad_pkg:
  - clog2 function.
  - Derived widths: ROW_W = PW+clog2(PIX), SAD_W = PW+clog2(PIX*ROWS), CNT_W = clog2(ROWS).
  - Pixel-slice helper.
- Sub-module sad_row_tree (PW, PIX): S1 abs-diff plus S2 registered adder tree, with valid passthrough and a synchronous flush input.
- Top: row counter, tags, accumulator and best tracker.

Test Plan:
- Legacy match (defaults): 8 rows pre=64'hFFFF_FFFF_FFFF_FFFF, crt=0, ids 5 -> 3 cycles after row 7, sad_valid=1, sad_data=16320, sad_id=5.
- Identical rows: 8 rows pre=crt=random -> sad_data=0; best_sad=0, best_valid=1 one cycle later.
- Gapped input: 8 rows each pixel |diff|=3, in_valid toggling 1/0 -> sad_data=192, sad_valid exactly once, 3 cycles after the last valid row.
- Min tracking, back-to-back candidates ids 0..3 with SADs 300, 100, 100, 200 -> four sad_valid pulses; final best_sad=100, best_id=1.
- search_clr at row 4 of a candidate, then a full clean candidate (diff 1/pixel, id 9) -> the partial candidate emits nothing; next sad_data=64, sad_id=9, best_id=9.
- rst_n low for 2 cycles during row 3 with sad_valid pending -> all outputs 0 immediately and no pulse. After release, a full block (diff 2/pixel) -> sad_data=128.

Source files
------------

// File: rtl/sad_pkg.sv
// Width helpers shared by the SAD accumulator and its per-row difference tree.
// Elaboration-time only; no logic.
package sad_pkg;

  localparam int PW_DEF    = 8;
  localparam int PIX_DEF   = 8;
  localparam int ROWS_DEF  = 8;
  localparam int IDX_W_DEF = 10;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  function automatic int row_w(input int pw, input int pix);
    return pw + clog2(pix);
  endfunction

  function automatic int sad_w(input int pw, input int pix, input int rows);
    return pw + clog2(pix * rows);
  endfunction

  // LSB of pixel idx inside a packed row.
  function automatic int pix_lsb(input int idx, input int pw);
    return idx * pw;
  endfunction

endpackage

// File: rtl/sad_row_tree.sv
// Per-pixel |pre-crt| (stage 1) then pairwise row-sum (stage 2), tags ride alongside.
// Latency 2 cycles, one row per cycle, no backpressure; flush_i kills the row already in stage 1.
module sad_row_tree
  import sad_pkg::*;
#(
  parameter int PW    = PW_DEF,
  parameter int PIX   = PIX_DEF,
  parameter int TAG_W = 1,
  localparam int ROW_W = row_w(PW, PIX)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush_i,
  input  logic              vld_i,
  input  logic [TAG_W-1:0]  tag_i,
  input  logic [PIX*PW-1:0] pre_i,
  input  logic [PIX*PW-1:0] crt_i,
  output logic              vld_o,
  output logic [TAG_W-1:0]  tag_o,
  output logic [ROW_W-1:0]  sum_o
);

  logic [PW-1:0]    diff_d [PIX];
  logic [PW-1:0]    diff_q [PIX];
  logic             vld1_q;
  logic [TAG_W-1:0] tag1_q;
  logic [ROW_W-1:0] sum_d;
  logic [ROW_W-1:0] sum_q;
  logic             vld2_q;
  logic [TAG_W-1:0] tag2_q;

  for (genvar g = 0; g < PIX; g++) begin : g_pix
    logic [PW-1:0] p;
    logic [PW-1:0] c;
    assign p = pre_i[pix_lsb(g, PW) +: PW];
    assign c = crt_i[pix_lsb(g, PW) +: PW];
    assign diff_d[g] = (p >= c) ? (p - c) : (c - p);
  end

  // Pairwise reduction: each pass halves the live node count.
  always_comb begin
    logic [ROW_W-1:0] node [PIX];
    for (int i = 0; i < PIX; i++) node[i] = ROW_W'(diff_q[i]);
    for (int w = PIX / 2; w >= 1; w = w / 2) begin
      for (int i = 0; i < w; i++) node[i] = node[2*i] + node[2*i+1];
    end
    sum_d = node[0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld1_q <= 1'b0;
      tag1_q <= '0;
      diff_q <= '{default: '0};
      vld2_q <= 1'b0;
      tag2_q <= '0;
      sum_q  <= '0;
    end else begin
      // A row arriving together with the flush belongs to the new window.
      vld1_q <= vld_i;
      tag1_q <= tag_i;
      diff_q <= diff_d;
      vld2_q <= vld1_q & ~flush_i;
      tag2_q <= tag1_q;
      sum_q  <= sum_d;
    end
  end

  assign vld_o = vld2_q;
  assign tag_o = tag2_q;
  assign sum_o = sum_q;

endmodule

// File: rtl/sad_acc_best.sv
// Streams block rows, accumulates SAD per candidate and tracks the window minimum.
// Row-to-sad_valid latency 3 cycles, best_* one cycle later; no backpressure, search_clr flushes.
module sad_acc_best
  import sad_pkg::*;
#(
  parameter int PW    = PW_DEF,
  parameter int PIX   = PIX_DEF,
  parameter int ROWS  = ROWS_DEF,
  parameter int IDX_W = IDX_W_DEF,
  localparam int ROW_W = row_w(PW, PIX),
  localparam int SAD_W = sad_w(PW, PIX, ROWS),
  localparam int CNT_W = clog2(ROWS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic              search_clr,
  input  logic [IDX_W-1:0]  cand_id,
  input  logic [PIX*PW-1:0] pre_frame,
  input  logic [PIX*PW-1:0] crt_frame,
  output logic [SAD_W-1:0]  sad_data,
  output logic              sad_valid,
  output logic [IDX_W-1:0]  sad_id,
  output logic [SAD_W-1:0]  best_sad,
  output logic [IDX_W-1:0]  best_id,
  output logic              best_valid
);

  typedef struct packed {
    logic             first;
    logic             last;
    logic [IDX_W-1:0] id;
  } tag_t;

  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_cur;
  logic [IDX_W-1:0] id_q, id_d;
  tag_t             in_tag, s2_tag;
  logic             s2_vld;
  logic [ROW_W-1:0] s2_sum;

  logic [SAD_W-1:0] acc_q, acc_d;
  logic [SAD_W-1:0] sad_data_q, sad_data_d;
  logic [IDX_W-1:0] sad_id_q, sad_id_d;
  logic             sad_valid_q, sad_valid_d;
  logic [SAD_W-1:0] best_sad_q, best_sad_d;
  logic [IDX_W-1:0] best_id_q, best_id_d;
  logic             best_valid_q, best_valid_d;

  always_comb begin
    cnt_cur      = search_clr ? '0 : cnt_q;
    in_tag.first = (cnt_cur == '0);
    in_tag.last  = (cnt_cur == CNT_W'(ROWS - 1));
    in_tag.id    = in_tag.first ? cand_id : id_q;
    cnt_d        = in_valid ? cnt_cur + CNT_W'(1) : cnt_cur;
    id_d         = in_valid ? in_tag.id : id_q;
  end

  sad_row_tree #(
    .PW    (PW),
    .PIX   (PIX),
    .TAG_W ($bits(tag_t))
  ) u_tree (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush_i (search_clr),
    .vld_i   (in_valid),
    .tag_i   (in_tag),
    .pre_i   (pre_frame),
    .crt_i   (crt_frame),
    .vld_o   (s2_vld),
    .tag_o   (s2_tag),
    .sum_o   (s2_sum)
  );

  always_comb begin
    acc_d        = acc_q;
    sad_valid_d  = 1'b0;
    sad_data_d   = sad_data_q;
    sad_id_d     = sad_id_q;
    best_sad_d   = best_sad_q;
    best_id_d    = best_id_q;
    best_valid_d = best_valid_q;

    if (!search_clr && s2_vld) begin
      acc_d = (s2_tag.first ? '0 : acc_q) + SAD_W'(s2_sum);
      if (s2_tag.last) begin
        sad_valid_d = 1'b1;
        sad_data_d  = acc_d;
        sad_id_d    = s2_tag.id;
      end
    end

    // Strict compare so a tie keeps the earlier candidate.
    if (search_clr) begin
      best_valid_d = 1'b0;
    end else if (sad_valid_q && (!best_valid_q || sad_data_q < best_sad_q)) begin
      best_sad_d   = sad_data_q;
      best_id_d    = sad_id_q;
      best_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q        <= '0;
      id_q         <= '0;
      acc_q        <= '0;
      sad_data_q   <= '0;
      sad_id_q     <= '0;
      sad_valid_q  <= 1'b0;
      best_sad_q   <= '0;
      best_id_q    <= '0;
      best_valid_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      id_q         <= id_d;
      acc_q        <= acc_d;
      sad_data_q   <= sad_data_d;
      sad_id_q     <= sad_id_d;
      sad_valid_q  <= sad_valid_d;
      best_sad_q   <= best_sad_d;
      best_id_q    <= best_id_d;
      best_valid_q <= best_valid_d;
    end
  end

  assign sad_data   = sad_data_q;
  assign sad_id     = sad_id_q;
  assign sad_valid  = sad_valid_q;
  assign best_sad   = best_sad_q;
  assign best_id    = best_id_q;
  assign best_valid = best_valid_q;

endmodule

// File: tb/tb_sad_acc_best.sv
// Scoreboard bench for sad_acc_best: driver pushes expected SADs with their due cycle,
// a negedge monitor pops/compares and checks the window minimum every cycle.
`timescale 1ns/1ps
module tb_sad_acc_best;

  localparam int PW    = 8;
  localparam int PIX   = 8;
  localparam int ROWS  = 8;
  localparam int IDX_W = 10;
  localparam int SAD_W = 14;
  localparam int DW    = PIX * PW;
  localparam int LAT   = 3;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic             in_valid = 1'b0;
  logic             search_clr = 1'b0;
  logic [IDX_W-1:0] cand_id = '0;
  logic [DW-1:0]    pre_frame = '0;
  logic [DW-1:0]    crt_frame = '0;
  logic [SAD_W-1:0] sad_data, best_sad;
  logic [IDX_W-1:0] sad_id, best_id;
  logic             sad_valid, best_valid;

  sad_acc_best #(.PW(PW), .PIX(PIX), .ROWS(ROWS), .IDX_W(IDX_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .search_clr (search_clr),
    .cand_id    (cand_id),
    .pre_frame  (pre_frame),
    .crt_frame  (crt_frame),
    .sad_data   (sad_data),
    .sad_valid  (sad_valid),
    .sad_id     (sad_id),
    .best_sad   (best_sad),
    .best_id    (best_id),
    .best_valid (best_valid)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int sad;
    int id;
    int due;
  } exp_t;

  exp_t exp_q[$];
  int   win_sad[$];
  int   win_id[$];

  // Reference model state: rows seen in the current candidate, running sum, captured id.
  int mcnt = 0;
  int macc = 0;
  int mid  = 0;

  task automatic chk(input string nm, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0d, required %0d", nm, cyc, act, req);
    end
  endtask

  function automatic int row_sad(input logic [DW-1:0] p, input logic [DW-1:0] c);
    int s;
    int a;
    int b;
    s = 0;
    for (int i = 0; i < PIX; i++) begin
      a = int'(p[i*PW +: PW]);
      b = int'(c[i*PW +: PW]);
      s += (a > b) ? a - b : b - a;
    end
    return s;
  endfunction

  task automatic drive(input bit v, input bit clr, input logic [DW-1:0] p,
                       input logic [DW-1:0] c, input int id);
    exp_t e;
    @(posedge clk);
    #1;
    in_valid   = v;
    search_clr = clr;
    pre_frame  = p;
    crt_frame  = c;
    cand_id    = IDX_W'(id);
    if (clr) begin
      mcnt = 0;
      macc = 0;
    end
    if (v) begin
      if (mcnt == 0) begin
        mid  = id;
        macc = 0;
      end
      macc += row_sad(p, c);
      if (mcnt == ROWS - 1) begin
        e.sad = macc;
        e.id  = mid;
        e.due = cyc + LAT;
        exp_q.push_back(e);
      end
      mcnt = (mcnt + 1) % ROWS;
    end
  endtask

  task automatic idle(input bit clr);
    drive(1'b0, clr, {$urandom, $urandom}, {$urandom, $urandom}, int'($urandom_range(0, 1023)));
  endtask

  task automatic do_reset(input int n);
    @(posedge clk);
    #1;
    rst_n      = 1'b0;
    in_valid   = 1'b0;
    search_clr = 1'b0;
    mcnt       = 0;
    macc       = 0;
    repeat (n) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic make_row(input int d[PIX], output logic [DW-1:0] p, output logic [DW-1:0] c);
    int base;
    p = '0;
    c = '0;
    for (int i = 0; i < PIX; i++) begin
      base = (d[i] >= 255) ? 0 : int'($urandom_range(0, 255 - d[i]));
      if (d[i] < 255 && $urandom_range(0, 1) == 1) begin
        p[i*PW +: PW] = PW'(base);
        c[i*PW +: PW] = PW'(base + d[i]);
      end else begin
        p[i*PW +: PW] = PW'(base + d[i]);
        c[i*PW +: PW] = PW'(base);
      end
    end
  endtask

  // uni: every pixel differs by val; otherwise val is the total SAD, packed greedily.
  // gap: 0 none, 1 one idle between rows, 2 random 0..2 idles.
  task automatic run_cand(input int id, input bit uni, input int val, input int gap,
                          input bit clr_first, input int nrows);
    int rem;
    int ng;
    int d[PIX];
    logic [DW-1:0] p, c;
    rem = val;
    for (int r = 0; r < nrows; r++) begin
      for (int i = 0; i < PIX; i++) begin
        if (uni) d[i] = val;
        else begin
          d[i] = (rem > 255) ? 255 : rem;
          rem -= d[i];
        end
      end
      make_row(d, p, c);
      ng = (gap == 2) ? int'($urandom_range(0, 2)) : gap;
      if (r > 0) for (int g = 0; g < ng; g++) idle(1'b0);
      drive(1'b1, clr_first && (r == 0), p, c, id);
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_sad_valid", int'(sad_valid), 0);
      chk("rst_sad_data", int'(sad_data), 0);
      chk("rst_sad_id", int'(sad_id), 0);
      chk("rst_best_valid", int'(best_valid), 0);
      chk("rst_best_sad", int'(best_sad), 0);
      chk("rst_best_id", int'(best_id), 0);
      while (exp_q.size() > 0 && exp_q[exp_q.size()-1].due >= cyc) exp_q.pop_back();
      win_sad.delete();
      win_id.delete();
    end else begin
      while (exp_q.size() > 0 && exp_q[0].due < cyc) begin
        checks++;
        errors++;
        $display("FAIL sad_missing at cycle %0d: got no sad_valid, required sad=%0d id=%0d",
                 exp_q[0].due, exp_q[0].sad, exp_q[0].id);
        exp_q.pop_front();
      end
      if (win_sad.size() == 0) begin
        chk("best_valid", int'(best_valid), 0);
      end else begin
        int bi;
        bi = 0;
        for (int k = 1; k < win_sad.size(); k++) if (win_sad[k] < win_sad[bi]) bi = k;
        chk("best_valid", int'(best_valid), 1);
        chk("best_sad", int'(best_sad), win_sad[bi]);
        chk("best_id", int'(best_id), win_id[bi]);
      end
      if (sad_valid) begin
        if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
          chk("sad_data", int'(sad_data), exp_q[0].sad);
          chk("sad_id", int'(sad_id), exp_q[0].id);
          win_sad.push_back(exp_q[0].sad);
          win_id.push_back(exp_q[0].id);
          exp_q.pop_front();
        end else begin
          checks++;
          errors++;
          $display("FAIL sad_unexpected at cycle %0d: got sad_valid=1 (sad=%0d), required 0",
                   cyc, sad_data);
        end
      end
      if (search_clr) begin
        while (exp_q.size() > 0 && exp_q[exp_q.size()-1].due > cyc) exp_q.pop_back();
        win_sad.delete();
        win_id.delete();
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not reach the end, required completion");
    $fatal(1, "timeout");
  end

  initial begin
    int prev;
    int v;
    do_reset(2);
    repeat (2) idle(1'b0);

    run_cand(5, 1'b1, 255, 0, 1'b0, ROWS);          // pre all ones, crt 0 -> 16320
    repeat (4) idle(1'b0);
    run_cand(1, 1'b1, 0, 0, 1'b0, ROWS);            // identical rows -> 0
    repeat (4) idle(1'b0);
    run_cand(2, 1'b1, 3, 1, 1'b0, ROWS);            // toggling in_valid -> 192
    repeat (5) idle(1'b0);

    idle(1'b1);
    run_cand(0, 1'b0, 300, 0, 1'b0, ROWS);
    run_cand(1, 1'b0, 100, 0, 1'b0, ROWS);
    run_cand(2, 1'b0, 100, 0, 1'b0, ROWS);
    run_cand(3, 1'b0, 200, 0, 1'b0, ROWS);
    repeat (5) idle(1'b0);

    run_cand(7, 1'b0, int'($urandom_range(0, 4000)), 0, 1'b0, 4);
    idle(1'b1);                                     // clear at row 4
    run_cand(9, 1'b1, 1, 0, 1'b0, ROWS);            // -> 64
    repeat (5) idle(1'b0);

    run_cand(10, 1'b0, int'($urandom_range(0, 4000)), 0, 1'b0, 5);
    run_cand(11, 1'b1, 4, 0, 1'b1, ROWS);           // clear and row 0 together -> 256
    repeat (5) idle(1'b0);

    run_cand(20, 1'b0, 500, 0, 1'b0, ROWS);
    run_cand(21, 1'b0, 50, 0, 1'b0, 2);
    do_reset(2);                                    // id 20 result still in flight
    run_cand(22, 1'b1, 2, 0, 1'b0, ROWS);           // -> 128
    repeat (5) idle(1'b0);

    prev = 1000;
    for (int k = 0; k < 60; k++) begin
      v = ($urandom_range(0, 3) == 0) ? prev : int'($urandom_range(0, 16320));
      prev = v;
      case ($urandom_range(0, 9))
        0: idle(1'b1);
        1: begin
          run_cand(int'($urandom_range(0, 1023)), 1'b0, int'($urandom_range(0, 16320)),
                   2, 1'b0, int'($urandom_range(1, ROWS - 1)));
          if ($urandom_range(0, 1) == 1) idle(1'b1);
          else begin
            run_cand(int'($urandom_range(0, 1023)), 1'b0, v, 2, 1'b1, ROWS);
            continue;
          end
        end
        default: ;
      endcase
      run_cand(int'($urandom_range(0, 1023)), 1'b0, v, 2, 1'b0, ROWS);
      if ($urandom_range(0, 3) == 0) idle(1'b0);
    end

    repeat (8) idle(1'b0);
    chk("drain_pending", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
